fetch_decode_ctrl: RTL

Pipeline-control block that consumes the load-use stall request and the EX-stage branch redirect. It owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register. It applies hold, bubble and flush actions to them. It also returns the IF/ID source-register fields and the ID/EX destination and MemRead fields to the load-use detector, which closes the hazard loop. Two saturating counters record stall and flush events for performance reporting.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/sat_counter.sv | 23 ++
 rtl/fetch_decode_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the fetch/decode pipeline control slice: reset and NOP
// values, instruction field positions and the ID/EX bubble encoding.
package pipe_pkg;

  localparam int          XLEN      = 32;
  localparam int          CTRL_W    = 8;
  localparam int          CNT_W     = 16;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;
  localparam int REG_W   = 5;

  // Non-control half of a bubble; the control bundle of a bubble is all zeros.
  localparam logic [REG_W-1:0] BUBBLE_RD      = '0;
  localparam logic             BUBBLE_MEMREAD = 1'b0;
  localparam logic             BUBBLE_VALID   = 1'b0;

  function automatic logic [REG_W-1:0] reg_field(input logic [31:0] instr, input int lsb);
    return instr[lsb +: REG_W];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/fetch_decode_ctrl.sv
// PC, IF/ID and ID/EX-control registers with reset > flush > stall > advance
// priority, plus stall/flush event counters.
module fetch_decode_ctrl
  import pipe_pkg::*;
#(
  parameter int                XLEN      = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC  = XLEN'(pipe_pkg::RESET_PC),
  parameter logic [31:0]       NOP_INSTR = pipe_pkg::NOP_INSTR,
  parameter int                CTRL_W    = pipe_pkg::CTRL_W,
  parameter int                CNT_W     = pipe_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rd,
  input  logic              id_memread,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   ifid_pc,
  output logic [31:0]       ifid_instr,
  output logic              ifid_valid,
  output logic [4:0]        ifid_rs1,
  output logic [4:0]        ifid_rs2,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [4:0]        idex_rd,
  output logic              idex_memread,
  output logic              idex_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [XLEN-1:0]   pc_reg;
  logic [XLEN-1:0]   ifid_pc_reg;
  logic [31:0]       ifid_instr_reg;
  logic              ifid_valid_reg;
  logic [CTRL_W-1:0] idex_ctrl_reg;
  logic [4:0]        idex_rd_reg;
  logic              idex_memread_reg;
  logic              idex_valid_reg;

  logic do_flush;
  logic do_stall;

  assign do_flush = branch_taken;
  assign do_stall = stall_in && !branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg           <= RESET_PC;
      ifid_pc_reg      <= '0;
      ifid_instr_reg   <= NOP_INSTR;
      ifid_valid_reg   <= 1'b0;
      idex_ctrl_reg    <= '0;
      idex_rd_reg      <= BUBBLE_RD;
      idex_memread_reg <= BUBBLE_MEMREAD;
      idex_valid_reg   <= BUBBLE_VALID;
    end else if (do_flush) begin
      pc_reg           <= branch_target;
      ifid_pc_reg      <= '0;
      ifid_instr_reg   <= NOP_INSTR;
      ifid_valid_reg   <= 1'b0;
      idex_ctrl_reg    <= '0;
      idex_rd_reg      <= BUBBLE_RD;
      idex_memread_reg <= BUBBLE_MEMREAD;
      idex_valid_reg   <= BUBBLE_VALID;
    end else if (do_stall) begin
      // PC and IF/ID hold; only ID/EX takes the bubble.
      idex_ctrl_reg    <= '0;
      idex_rd_reg      <= BUBBLE_RD;
      idex_memread_reg <= BUBBLE_MEMREAD;
      idex_valid_reg   <= BUBBLE_VALID;
    end else begin
      pc_reg         <= pc_reg + XLEN'(4);
      ifid_pc_reg    <= pc_reg;
      ifid_instr_reg <= imem_instr;
      ifid_valid_reg <= 1'b1;
      if (ifid_valid_reg) begin
        idex_ctrl_reg    <= id_ctrl;
        idex_rd_reg      <= id_rd;
        idex_memread_reg <= id_memread;
        idex_valid_reg   <= 1'b1;
      end else begin
        idex_ctrl_reg    <= '0;
        idex_rd_reg      <= BUBBLE_RD;
        idex_memread_reg <= BUBBLE_MEMREAD;
        idex_valid_reg   <= BUBBLE_VALID;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (do_stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (do_flush),
    .cnt   (flush_cnt)
  );

  assign pc_out       = pc_reg;
  assign ifid_pc      = ifid_pc_reg;
  assign ifid_instr   = ifid_instr_reg;
  assign ifid_valid   = ifid_valid_reg;
  assign ifid_rs1     = reg_field(ifid_instr_reg, RS1_LSB);
  assign ifid_rs2     = reg_field(ifid_instr_reg, RS2_LSB);
  assign idex_ctrl    = idex_ctrl_reg;
  assign idex_rd      = idex_rd_reg;
  assign idex_memread = idex_memread_reg;
  assign idex_valid   = idex_valid_reg;

endmodule
